shift_sequencer: RTL and testbench



---
 rtl/shift_sequencer.sv | 149 ++++++++++++++
 tb/tb_shift_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// ARM addressing-mode-1 shifter operand, computed by stepping a working register STEP bits per cycle.
// Start/busy/done handshake; result and carry_out hold from DONE until the next accepted start.
module shift_sequencer #(
    parameter int STEP = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        imm_mode,
    input  logic [11:0] shifter_operand,
    input  logic [31:0] rm_value,
    input  logic [7:0]  rs_value,
    input  logic        c_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        carry_out
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    typedef enum logic [2:0] {SH_LSL, SH_LSR, SH_ASR, SH_ROR, SH_RRX} shift_t;

    localparam logic [5:0] STEP_W = 6'(STEP);

    state_t     state;
    shift_t     kind;
    logic [5:0] remaining;
    logic       c_lat;

    shift_t     dec_kind;
    logic [5:0] dec_count;
    logic [31:0] dec_value;
    logic [4:0] imm_amt;

    // Decode the operand into a starting value, shift kind and iteration count.
    always_comb begin
        dec_kind  = shift_t'({1'b0, shifter_operand[6:5]});
        dec_value = rm_value;
        dec_count = '0;
        imm_amt   = shifter_operand[11:7];
        if (imm_mode) begin
            dec_kind  = SH_ROR;
            dec_value = {24'b0, shifter_operand[7:0]};
            dec_count = {1'b0, shifter_operand[11:8], 1'b0};
        end else if (!shifter_operand[4]) begin
            if (imm_amt != 5'd0) begin
                dec_count = {1'b0, imm_amt};
            end else begin
                case (dec_kind)
                    SH_LSR, SH_ASR: dec_count = 6'd32;
                    SH_ROR: begin
                        dec_kind  = SH_RRX;
                        dec_count = 6'd1;
                    end
                    default: dec_count = '0;
                endcase
            end
        end else if (rs_value != 8'd0) begin
            // LSL/LSR saturate at 33 so the final step pushes the last data bit out, leaving carry 0.
            case (dec_kind)
                SH_LSL, SH_LSR: dec_count = (rs_value > 8'd33) ? 6'd33 : rs_value[5:0];
                SH_ASR:         dec_count = (rs_value > 8'd32) ? 6'd32 : rs_value[5:0];
                default:        dec_count = (rs_value[4:0] == 5'd0) ? 6'd32 : {1'b0, rs_value[4:0]};
            endcase
        end
    end

    logic [5:0]  k;
    logic [63:0] wide;
    logic [31:0] step_value;
    logic        step_carry;

    always_comb begin
        k          = (remaining < STEP_W) ? remaining : STEP_W;
        wide       = '0;
        step_value = result;
        step_carry = carry_out;
        case (kind)
            SH_LSL: begin
                wide       = {32'b0, result} << k;
                step_value = wide[31:0];
                step_carry = wide[32];
            end
            SH_LSR: begin
                wide       = {result, 32'b0} >> k;
                step_value = wide[63:32];
                step_carry = wide[31];
            end
            SH_ASR: begin
                wide       = $signed({result, 32'b0}) >>> k;
                step_value = wide[63:32];
                step_carry = wide[31];
            end
            SH_ROR: begin
                step_value = (result >> k) | (result << (6'd32 - k));
                step_carry = step_value[31];
            end
            SH_RRX: begin
                step_value = {c_lat, result[31:1]};
                step_carry = result[0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            kind      <= SH_LSL;
            remaining <= '0;
            c_lat     <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                SHIFT: begin
                    result    <= step_value;
                    carry_out <= step_carry;
                    remaining <= remaining - k;
                    if (remaining == k) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    // IDLE and DONE both accept a request.
                    done  <= 1'b0;
                    state <= IDLE;
                    if (start) begin
                        kind      <= dec_kind;
                        remaining <= dec_count;
                        c_lat     <= c_in;
                        result    <= dec_value;
                        carry_out <= c_in;
                        if (dec_count == 6'd0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= SHIFT;
                            busy  <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: two instances (STEP=1 and STEP=4) against a whole-shift reference model.
module tb_shift_sequencer;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        imm_mode;
    logic [11:0] op;
    logic [31:0] rm;
    logic [7:0]  rs;
    logic        cin;

    logic        busy_w [2];
    logic        done_w [2];
    logic        carry_w[2];
    logic [31:0] res_w  [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        shift_sequencer #(.STEP(g == 0 ? 1 : 4)) dut (
            .clk(clk), .reset(reset), .start(start), .imm_mode(imm_mode),
            .shifter_operand(op), .rm_value(rm), .rs_value(rs), .c_in(cin),
            .busy(busy_w[g]), .done(done_w[g]), .result(res_w[g]), .carry_out(carry_w[g])
        );
    end

    typedef struct {
        logic [31:0] res;
        logic        c;
        int          cnt;
        int          due;
    } exp_t;

    exp_t        sb[2][$];
    logic [31:0] last_res[2];
    logic        last_c[2];
    int          free_at[2];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] ror32(input logic [31:0] v, input int n);
        if (n == 0) return v;
        return (v >> n) | (v << (32 - n));
    endfunction

    // Architectural result of the whole shift in one go, plus the iteration count.
    function automatic exp_t model(input logic im, input logic [11:0] o, input logic [31:0] r,
                                   input logic [7:0] s, input logic c);
        exp_t e;
        int n;
        int ty;
        e.res = r; e.c = c; e.cnt = 0; e.due = 0;
        if (im) begin
            n = 2 * int'(o[11:8]);
            e.cnt = n;
            e.res = ror32({24'b0, o[7:0]}, n);
            if (n != 0) e.c = e.res[31];
            return e;
        end
        ty = int'(o[6:5]);
        if (!o[4]) begin
            n = int'(o[11:7]);
            if (n == 0) begin
                if (ty == 0) return e;
                if (ty == 3) begin
                    e.res = {c, r[31:1]}; e.c = r[0]; e.cnt = 1;
                    return e;
                end
                n = 32;
            end
        end else begin
            n = int'(s);
            if (n == 0) return e;
        end
        case (ty)
            0: begin
                e.cnt = (n > 33) ? 33 : n;
                e.res = (n >= 32) ? 32'h0 : r << n;
                e.c   = (n > 32) ? 1'b0 : r[32 - n];
            end
            1: begin
                e.cnt = (n > 33) ? 33 : n;
                e.res = (n >= 32) ? 32'h0 : r >> n;
                e.c   = (n > 32) ? 1'b0 : r[n - 1];
            end
            2: begin
                e.cnt = (n > 32) ? 32 : n;
                e.res = (n >= 32) ? {32{r[31]}} : 32'($signed(r) >>> n);
                e.c   = (n >= 32) ? r[31] : r[n - 1];
            end
            default: begin
                e.cnt = (n % 32 == 0) ? 32 : n % 32;
                e.res = ror32(r, n % 32);
                e.c   = e.res[31];
            end
        endcase
        return e;
    endfunction

    function automatic int lat(input int cnt, input int g);
        int s;
        s = (g == 0) ? 1 : 4;
        return 1 + (cnt + s - 1) / s;
    endfunction

    task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d cycle %0d: got %h expected %h", name, g, cyc, act, exp);
        end
    endtask

    // Monitor first, then the acceptance model, so a DONE-cycle start is seen after the pop.
    always @(negedge clk) begin
        exp_t e;
        logic due;
        logic ebusy;
        for (int g = 0; g < 2; g++) begin
            if (reset) begin
                sb[g].delete();
                last_res[g] = '0;
                last_c[g]   = 1'b0;
                free_at[g]  = 0;
            end else begin
                due   = (sb[g].size() > 0) && (sb[g][0].due == cyc);
                ebusy = (sb[g].size() > 0) && !due;
                chk("busy", g, 32'(busy_w[g]), 32'(ebusy));
                chk("done", g, 32'(done_w[g]), 32'(due));
                if (due) begin
                    chk("result", g, res_w[g], sb[g][0].res);
                    chk("carry", g, 32'(carry_w[g]), 32'(sb[g][0].c));
                    last_res[g] = sb[g][0].res;
                    last_c[g]   = sb[g][0].c;
                    void'(sb[g].pop_front());
                end else if (!ebusy) begin
                    chk("hold_result", g, res_w[g], last_res[g]);
                    chk("hold_carry", g, 32'(carry_w[g]), 32'(last_c[g]));
                end
                if (start && cyc >= free_at[g]) begin
                    e = model(imm_mode, op, rm, rs, cin);
                    e.due = cyc + lat(e.cnt, g);
                    free_at[g] = e.due;
                    sb[g].push_back(e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic im, input logic [11:0] o, input logic [31:0] r,
                         input logic [7:0] s, input logic c);
        start = 1'b1; imm_mode = im; op = o; rm = r; rs = s; cin = c;
        step();
        start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            if (sb[0].size() == 0 && sb[1].size() == 0) break;
            step();
        end
        step();
    endtask

    task automatic rand_ops();
        imm_mode = ($urandom_range(0, 3) == 0);
        op  = 12'($urandom);
        rm  = $urandom;
        cin = 1'($urandom);
        case ($urandom_range(0, 3))
            0:       rs = 8'($urandom_range(0, 40));
            1:       rs = 8'($urandom_range(31, 33));
            2:       rs = 8'd0;
            default: rs = 8'($urandom);
        endcase
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; imm_mode = 1'b0; op = '0; rm = '0; rs = '0; cin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        step();

        issue(1'b1, 12'h4FF, 32'h0, 8'h0, 1'b0);                          wait_idle();
        issue(1'b0, {5'd4, 2'b00, 1'b0, 4'h0}, 32'h80000001, 8'h0, 1'b0); wait_idle();
        issue(1'b0, {5'd0, 2'b11, 1'b0, 4'h0}, 32'h00000003, 8'h0, 1'b1); wait_idle();
        issue(1'b0, {5'd0, 2'b01, 1'b0, 4'h0}, 32'h80000000, 8'h0, 1'b0); wait_idle();
        issue(1'b0, {4'h0, 1'b0, 2'b01, 1'b1, 4'h0}, 32'hFFFFFFFF, 8'h28, 1'b0); wait_idle();
        issue(1'b0, {4'h0, 1'b1, 2'b11, 1'b1, 4'h0}, 32'h80000000, 8'h20, 1'b0); wait_idle();
        for (int t = 0; t < 4; t++) begin
            issue(1'b0, {4'h0, 1'b0, 2'(t), 1'b1, 4'h0}, 32'h12345678 + 32'(t), 8'h0, 1'b1);
            wait_idle();
        end

        // start held through SHIFT with changing operands
        issue(1'b0, {5'd10, 2'b00, 1'b0, 4'h0}, 32'h0F0F0F0F, 8'h0, 1'b0);
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rand_ops();
            step();
        end
        start = 1'b0;
        wait_idle();

        // back-to-back: new start in the DONE cycle of the STEP=1 instance
        issue(1'b0, {5'd6, 2'b10, 1'b0, 4'h0}, 32'h80000010, 8'h0, 1'b0);
        for (int i = 0; i < lat(6, 0) - 1; i++) step();
        issue(1'b0, {5'd3, 2'b01, 1'b0, 4'h0}, 32'hA5A5A5A5, 8'h0, 1'b1);
        wait_idle();

        // reset in cycle 3 of a 20-count operation
        issue(1'b0, {5'd20, 2'b00, 1'b0, 4'h0}, 32'hDEADBEEF, 8'h0, 1'b1);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (3) step();
        issue(1'b0, {5'd5, 2'b11, 1'b0, 4'h0}, 32'h0000001F, 8'h0, 1'b0);
        wait_idle();

        for (int n = 0; n < 80; n++) begin
            start = 1'b1;
            for (int h = 0; h < int'($urandom_range(1, 3)); h++) begin
                rand_ops();
                step();
            end
            start = 1'b0;
            if ($urandom_range(0, 1) == 1) wait_idle();
        end
        wait_idle();
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
